// File: rtl/pjdl_frame_buf_pkg.sv
// rtl/pjdl_frame_buf_pkg.sv - shared types and constants for the PJDL store-and-forward frame buffer
package pjdl_frame_buf_pkg;

   typedef enum logic {
      FILL = 1'b0,
      DROP = 1'b1
   } buf_state_e;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } buf_entry_t;

   localparam int unsigned StatsWidth = 16;

endpackage

// File: rtl/pjdl_axis_frame_buffer.sv
// rtl/pjdl_axis_frame_buffer.sv - store-and-forward byte FIFO between the iDMA stream and the PJDL transmitter
// Defining PJDL_FRAME_BUF_STATS_EN adds saturating frames_sent_o / frames_dropped_o counters.
module pjdl_axis_frame_buffer
   import pjdl_frame_buf_pkg::*;
#(
   parameter int unsigned Depth     = 64,
   parameter int unsigned MaxFrames = 4,
   localparam int unsigned PW = $clog2(Depth) + 1,
   localparam int unsigned FW = $clog2(MaxFrames + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [7:0]            s_tdata_i,
   input  logic                  s_tlast_i,
   input  logic                  s_tvalid_i,
   output logic                  s_tready_o,
   output logic [7:0]            m_tdata_o,
   output logic                  m_tlast_o,
   output logic                  m_tvalid_o,
   input  logic                  m_tready_i,
   output logic [FW-1:0]         frame_cnt_o,
   output logic [PW-1:0]         level_o,
`ifdef PJDL_FRAME_BUF_STATS_EN
   output logic [StatsWidth-1:0] frames_sent_o,
   output logic [StatsWidth-1:0] frames_dropped_o,
`endif
   output logic                  drop_o
);

   localparam int unsigned AW = PW - 1;

   buf_entry_t    mem [Depth];
   buf_state_e    state_q;
   logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
   logic [PW-1:0] level, partial;
   logic [FW-1:0] frame_cnt;
   logic          drop_q;
   logic          full, oversize, wr_en, commit, rd_en, rd_last;

   // Pointers carry a wrap bit, so a full buffer is distinguishable from an empty one.
   assign level      = wr_ptr - rd_ptr;
   assign partial    = wr_ptr - commit_ptr;
   assign full       = (level == PW'(Depth));
   assign oversize   = (state_q == FILL) && s_tvalid_i && (partial == PW'(Depth));
   assign s_tready_o = (state_q == DROP) || (!full && (frame_cnt < FW'(MaxFrames)));
   assign wr_en      = (state_q == FILL) && s_tvalid_i && s_tready_o;
   assign commit     = wr_en && s_tlast_i;

   assign m_tvalid_o = (frame_cnt != '0);
   assign m_tlast_o  = mem[rd_ptr[AW-1:0]].last;
   assign m_tdata_o  = mem[rd_ptr[AW-1:0]].data;
   assign rd_en      = m_tvalid_o && m_tready_i;
   assign rd_last    = rd_en && m_tlast_o;

   assign frame_cnt_o = frame_cnt;
   assign level_o     = level;
   assign drop_o      = drop_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < Depth; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= '{last: s_tlast_i, data: s_tdata_i};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= FILL;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         frame_cnt  <= '0;
         drop_q     <= 1'b0;
      end else begin
         drop_q <= 1'b0;
         case (state_q)
            FILL: begin
               // An oversize frame fills the whole array uncommitted: rewind and sink the rest.
               if (oversize) begin
                  wr_ptr  <= commit_ptr;
                  drop_q  <= 1'b1;
                  state_q <= DROP;
               end else if (wr_en) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (s_tlast_i) begin
                     commit_ptr <= wr_ptr + 1'b1;
                  end
               end
            end
            DROP: begin
               if (s_tvalid_i && s_tlast_i) begin
                  state_q <= FILL;
               end
            end
            default: state_q <= FILL;
         endcase

         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         if (commit && !rd_last) begin
            frame_cnt <= frame_cnt + 1'b1;
         end else if (rd_last && !commit) begin
            frame_cnt <= frame_cnt - 1'b1;
         end
      end
   end

`ifdef PJDL_FRAME_BUF_STATS_EN
   logic [StatsWidth-1:0] sent_q, dropped_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sent_q    <= '0;
         dropped_q <= '0;
      end else begin
         if (rd_last && (sent_q != '1)) begin
            sent_q <= sent_q + 1'b1;
         end
         if (drop_q && (dropped_q != '1)) begin
            dropped_q <= dropped_q + 1'b1;
         end
      end
   end

   assign frames_sent_o    = sent_q;
   assign frames_dropped_o = dropped_q;
`endif

endmodule

// File: tb/tb_pjdl_axis_frame_buffer.sv
// tb/tb_pjdl_axis_frame_buffer.sv - self-checking bench for pjdl_axis_frame_buffer against a queue-based frame model
module tb_pjdl_axis_frame_buffer;

   localparam int DEPTH = 16;
   localparam int MAXF  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_tdata = '0;
   logic       s_tlast = 1'b0;
   logic       s_tvalid = 1'b0;
   logic       s_tready;
   logic [7:0] m_tdata;
   logic       m_tlast;
   logic       m_tvalid;
   logic       m_tready = 1'b0;
   logic [2:0] frame_cnt;
   logic [4:0] level;
   logic       drop;
`ifdef PJDL_FRAME_BUF_STATS_EN
   logic [15:0] frames_sent;
   logic [15:0] frames_dropped;
`endif

   pjdl_axis_frame_buffer #(.Depth(DEPTH), .MaxFrames(MAXF)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .s_tdata_i   (s_tdata),
      .s_tlast_i   (s_tlast),
      .s_tvalid_i  (s_tvalid),
      .s_tready_o  (s_tready),
      .m_tdata_o   (m_tdata),
      .m_tlast_o   (m_tlast),
      .m_tvalid_o  (m_tvalid),
      .m_tready_i  (m_tready),
      .frame_cnt_o (frame_cnt),
      .level_o     (level),
`ifdef PJDL_FRAME_BUF_STATS_EN
      .frames_sent_o    (frames_sent),
      .frames_dropped_o (frames_dropped),
`endif
      .drop_o      (drop)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int drop_seen = 0;

   // Model: committed bytes awaiting readout, the frame being assembled, and the sink mode.
   logic [8:0] st_q[$];
   logic [8:0] pt_q[$];
   logic [8:0] out_log[$];
   logic [8:0] tx_q[$];
   int  frames = 0;
   bit  dropping = 0;
   bit  drop_pend = 0;
   int  sent_cnt = 0;
   int  dropped_cnt = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_sready();
      return dropping || ((st_q.size() + pt_q.size()) < DEPTH && frames < MAXF);
   endfunction

   task automatic model_reset();
      st_q.delete();
      pt_q.delete();
      frames = 0;
      dropping = 0;
      drop_pend = 0;
      sent_cnt = 0;
      dropped_cnt = 0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] d, input bit l, input bit mr, output bit acc);
      bit rdy;
      rdy = exp_sready();
      acc = v && rdy;
      if (drop_pend && dropped_cnt < 65535) dropped_cnt++;
      drop_pend = 0;
      if (frames != 0 && mr) begin
         out_log.push_back(st_q[0]);
         if (st_q[0][8]) begin
            frames--;
            if (sent_cnt < 65535) sent_cnt++;
         end
         void'(st_q.pop_front());
      end
      if (dropping) begin
         if (v && l) dropping = 0;
      end else if (v && pt_q.size() == DEPTH) begin
         pt_q.delete();
         dropping = 1;
         drop_pend = 1;
      end else if (acc) begin
         pt_q.push_back({l, d});
         if (l) begin
            foreach (pt_q[i]) st_q.push_back(pt_q[i]);
            pt_q.delete();
            frames++;
         end
      end
   endtask

   always @(negedge clk) begin
      if (drop) drop_seen++;
      chk("s_tready", s_tready, exp_sready());
      chk("m_tvalid", m_tvalid, frames != 0);
      chk("frame_cnt", frame_cnt, frames);
      chk("level", level, st_q.size() + pt_q.size());
      chk("drop", drop, drop_pend);
      if (frames != 0) begin
         chk("m_tdata", m_tdata, st_q[0][7:0]);
         chk("m_tlast", m_tlast, st_q[0][8]);
      end
`ifdef PJDL_FRAME_BUF_STATS_EN
      chk("frames_sent", frames_sent, sent_cnt);
      chk("frames_dropped", frames_dropped, dropped_cnt);
`endif
   end

   task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit mr, output bit acc);
      s_tvalid = v;
      s_tdata  = d;
      s_tlast  = l;
      m_tready = mr;
      @(posedge clk);
      model_step(v, d, l, mr, acc);
      #1;
   endtask

   task automatic push_frame(input int len);
      for (int i = 0; i < len; i++) begin
         tx_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(255))});
      end
   endtask

   // mr_mode: 0/1 fixed PJDL ready, 2 random ready.
   task automatic drive(input int max_cycles, input int vprob, input int mr_mode, input bit must_finish);
      int n;
      bit acc, v, mr;
      n = 0;
      while (tx_q.size() != 0 && n < max_cycles) begin
         v  = ($urandom_range(99) < vprob);
         mr = (mr_mode == 2) ? ($urandom_range(99) < 60) : (mr_mode == 1);
         cycle(v, tx_q[0][7:0], tx_q[0][8], mr, acc);
         if (acc) void'(tx_q.pop_front());
         n++;
      end
      if (must_finish && tx_q.size() != 0) begin
         errors++;
         $display("FAIL drive_timeout: got %0d beats left expected 0", tx_q.size());
      end
   endtask

   task automatic drain(input int max_cycles);
      int n;
      bit acc;
      n = 0;
      while (frames != 0 && n < max_cycles) begin
         cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
         n++;
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
      chk("drain_done", frames, 0);
   endtask

   task automatic do_reset();
      s_tvalid = 0;
      m_tready = 0;
      rst = 1;
      model_reset();
      tx_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   initial begin
      bit acc;
      model_reset();
      @(negedge clk);
      chk("reset_m_tdata", m_tdata, 0);
      chk("reset_m_tlast", m_tlast, 0);
      chk("reset_s_tready", s_tready, 1);
      @(posedge clk);
      #1 rst = 0;

      // Single 3-byte frame: valid only after the last byte is in.
      out_log.delete();
      cycle(1, 8'h11, 0, 1, acc);
      cycle(1, 8'h22, 0, 1, acc);
      chk("lat_not_yet", m_tvalid, 0);
      cycle(1, 8'h33, 1, 1, acc);
      chk("lat_valid", m_tvalid, 1);
      chk("lat_first", m_tdata, 8'h11);
      chk("lat_cnt", frame_cnt, 1);
      drain(20);
      chk("s1_len", out_log.size(), 3);
      if (out_log.size() == 3) begin
         chk("s1_b0", out_log[0], 9'h011);
         chk("s1_b1", out_log[1], 9'h022);
         chk("s1_b2", out_log[2], 9'h133);
      end

      // Five 2-byte frames with PJDL stalled.
      out_log.delete();
      repeat (5) push_frame(2);
      drive(20, 100, 0, 0);
      chk("s2_cnt", frame_cnt, 4);
      chk("s2_level", level, 8);
      chk("s2_ready", s_tready, 0);
      drive(50, 100, 1, 1);
      drain(50);
      chk("s2_len", out_log.size(), 10);

      // 20-byte frame into 16 entries is dropped; the next frame passes.
      out_log.delete();
      drop_seen = 0;
      push_frame(20);
      drive(40, 100, 0, 1);
      chk("s3_drops", drop_seen, 1);
      chk("s3_level", level, 0);
      push_frame(2);
      drive(20, 100, 1, 1);
      drain(20);
      chk("s3_len", out_log.size(), 2);

      // Stall at full, then drain without a drop.
      out_log.delete();
      drop_seen = 0;
      push_frame(10);
      drive(30, 100, 0, 1);
      push_frame(12);
      drive(30, 100, 0, 0);
      chk("s4_level", level, 16);
      chk("s4_ready", s_tready, 0);
      drive(60, 100, 1, 1);
      drain(60);
      chk("s4_len", out_log.size(), 22);
      chk("s4_drops", drop_seen, 0);

      // Reset mid-frame.
      push_frame(5);
      drive(3, 100, 1, 0);
      do_reset();
      @(negedge clk);
      chk("rst_level", level, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_ready", s_tready, 1);
      out_log.delete();
      push_frame(4);
      drive(20, 100, 1, 1);
      drain(20);
      chk("rst_len", out_log.size(), 4);

`ifdef PJDL_FRAME_BUF_STATS_EN
      do_reset();
      repeat (3) push_frame(3);
      push_frame(18);
      drive(100, 100, 1, 1);
      drain(50);
      chk("stats_sent", frames_sent, 3);
      chk("stats_dropped", frames_dropped, 1);
`endif

      // Randomized traffic including oversize frames.
      for (int f = 0; f < 200; f++) begin
         push_frame($urandom_range(1, 20));
         drive(2000, 70, 2, 1);
      end
      drain(400);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
